seven_seg_capture: RTL and testbench

Receive-side monitor for the four-digit multiplexed 7-segment bus. It samples the anode and segment lines produced by the display driver and filters out setup/transition glitches. It decodes each stable lit pattern back to a 4-bit hex character and assembles complete 4-digit frames. It is used for on-chip loopback self-test of the display path and as a bench-side checker.

---
 rtl/seven_seg_pkg.sv | 32 +++
 rtl/seg7_to_hex.sv | 34 +++
 rtl/seven_seg_capture.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and hex segment patterns for the 7-segment capture monitor.
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] hexchar_t;

  typedef enum logic {TRACK, HOLD} cap_state_t;

  // Lit-segment patterns, bit order {a,b,c,d,e,f,g}
  localparam seg7_t SEG_0 = 7'h7E;
  localparam seg7_t SEG_1 = 7'h30;
  localparam seg7_t SEG_2 = 7'h6D;
  localparam seg7_t SEG_3 = 7'h79;
  localparam seg7_t SEG_4 = 7'h33;
  localparam seg7_t SEG_5 = 7'h5B;
  localparam seg7_t SEG_6 = 7'h5F;
  localparam seg7_t SEG_7 = 7'h70;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h7B;
  localparam seg7_t SEG_A = 7'h77;
  localparam seg7_t SEG_B = 7'h1F;
  localparam seg7_t SEG_C = 7'h4E;
  localparam seg7_t SEG_D = 7'h3D;
  localparam seg7_t SEG_E = 7'h4F;
  localparam seg7_t SEG_F = 7'h47;

  // Next expected scan index, given a prefix-shaped seen mask
  function automatic logic [1:0] next_index(input logic [3:0] seen);
    return 2'($countones(seen));
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment decoder: lit pattern -> hex character, hit=0 on unknown pattern.
module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  seg7_t    seg,
  output hexchar_t char,
  output logic     hit
);

  always_comb begin
    hit  = 1'b1;
    char = '0;
    case (seg)
      SEG_0:   char = 4'h0;
      SEG_1:   char = 4'h1;
      SEG_2:   char = 4'h2;
      SEG_3:   char = 4'h3;
      SEG_4:   char = 4'h4;
      SEG_5:   char = 4'h5;
      SEG_6:   char = 4'h6;
      SEG_7:   char = 4'h7;
      SEG_8:   char = 4'h8;
      SEG_9:   char = 4'h9;
      SEG_A:   char = 4'hA;
      SEG_B:   char = 4'hB;
      SEG_C:   char = 4'hC;
      SEG_D:   char = 4'hD;
      SEG_E:   char = 4'hE;
      SEG_F:   char = 4'hF;
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for the 4-digit multiplexed 7-segment bus; rebuilds frames.
// Optional scan-order checking: define SEVEN_SEG_CAPTURE_ORDER_CHECK_EN (adds err_order).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_sync,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        err_seg,
  output logic        err_multi
`ifdef SEVEN_SEG_CAPTURE_ORDER_CHECK_EN
  , output logic      err_order
`endif
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       an_m, an_s;
  seg7_t            seg_m, seg_s, seg_n;
  logic [10:0]      pat, pat_q;
  logic             pat_same;
  logic [CNT_W-1:0] stable_cnt;
  cap_state_t       state, state_nx;
  logic             accept;

  logic [3:0]       an_low;
  logic             is_blank, is_single;
  logic [1:0]       idx;
  hexchar_t         dec_char;
  logic             dec_hit;

  logic [3:0]       seen, seen_nx;
  hexchar_t [3:0]   dbuf, dbuf_nx;
  logic             set_seg, set_multi, set_order, frame_done;

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      an_m  <= '0;
      an_s  <= '0;
      seg_m <= '0;
      seg_s <= '0;
    end else begin
      an_m  <= an;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;
    end
  end

  always_comb begin
    seg_n    = SEG_ACTIVE_LOW ? ~seg_s : seg_s;
    pat      = {an_s, seg_n};
    pat_same = (pat == pat_q);
  end

  // pat_q resets to all-ones so the zeroed synchronizer contents never look stable
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      pat_q      <= '1;
      stable_cnt <= '0;
    end else begin
      pat_q <= pat;
      if (!pat_same)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) state <= TRACK;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      TRACK:   if (pat_same && stable_cnt == CNT_MAX) state_nx = HOLD;
      HOLD:    if (!pat_same) state_nx = TRACK;
      default: state_nx = TRACK;
    endcase
  end

  always_comb begin
    accept = (state == TRACK) && pat_same && (stable_cnt == CNT_MAX);
  end

  seg7_to_hex u_dec (
    .seg  (seg_n),
    .char (dec_char),
    .hit  (dec_hit)
  );

  always_comb begin
    an_low    = ~an_s;
    is_blank  = (an_low == '0);
    is_single = ($countones(an_low) == 1);
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    seen_nx    = seen;
    dbuf_nx    = dbuf;
    set_seg    = 1'b0;
    set_multi  = 1'b0;
    set_order  = 1'b0;
    frame_done = 1'b0;
    if (accept && !is_blank) begin
      if (!is_single) begin
        set_multi = 1'b1;
      end else if (!dec_hit) begin
        set_seg = 1'b1;
      end else begin
`ifdef SEVEN_SEG_CAPTURE_ORDER_CHECK_EN
        if (idx != next_index(seen)) begin
          set_order = 1'b1;
          seen_nx   = '0;
          if (idx == 2'd0) begin
            dbuf_nx[0] = dec_char;
            seen_nx[0] = 1'b1;
          end
        end else begin
          dbuf_nx[idx] = dec_char;
          seen_nx[idx] = 1'b1;
        end
`else
        dbuf_nx[idx] = dec_char;
        seen_nx[idx] = 1'b1;
`endif
        if (seen_nx == 4'b1111) frame_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      seen        <= '0;
      dbuf        <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      err_seg     <= 1'b0;
      err_multi   <= 1'b0;
    end else begin
      seen        <= frame_done ? '0 : seen_nx;
      dbuf        <= dbuf_nx;
      frame_valid <= frame_done;
      if (frame_done) begin
        digits      <= dbuf_nx;
        frame_count <= frame_count + 8'd1;
      end
      err_seg   <= (err_seg   & ~err_clr) | set_seg;
      err_multi <= (err_multi & ~err_clr) | set_multi;
    end
  end

`ifdef SEVEN_SEG_CAPTURE_ORDER_CHECK_EN
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) err_order <= 1'b0;
    else            err_order <= (err_order & ~err_clr) | set_order;
  end
`else
  logic unused_order;
  always_comb unused_order = set_order;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed self-checking bench for seven_seg_capture (default build, STABLE_CYCLES=8, active-low segs).
module tb_seven_seg_capture;

  logic        clk;
  logic        reset_sync;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        err_clr;
  logic [15:0] digits;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        err_seg;
  logic        err_multi;

  int unsigned n_total;
  int unsigned n_bad;
  int unsigned fv_cnt;
  int unsigned fv_mark;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int unsigned off_tab [4] = '{0, 1, 5, 9};

  seven_seg_capture #(.STABLE_CYCLES(8), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .reset_sync  (reset_sync),
    .an          (an),
    .seg         (seg),
    .err_clr     (err_clr),
    .digits      (digits),
    .frame_valid (frame_valid),
    .frame_count (frame_count),
    .err_seg     (err_seg),
    .err_multi   (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid) fv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] lit, input int unsigned n);
    an  = a;
    seg = ~lit;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input int unsigned k, input int unsigned ch, input int unsigned n);
    logic [3:0] a;
    a = ~(4'b0001 << k);
    drive(a, seg_tab[ch], n);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_total    = 0;
    n_bad      = 0;
    fv_cnt     = 0;
    reset_sync = 1'b1;
    err_clr    = 1'b0;
    an         = 4'hF;
    seg        = 7'h7F;
    repeat (3) @(negedge clk);
    reset_sync = 1'b0;
    @(negedge clk);

    check("rst_digits", 32'(digits), 32'h0);
    check("rst_fv",     32'(frame_valid), 32'h0);
    check("rst_fc",     32'(frame_count), 32'h0);
    check("rst_eseg",   32'(err_seg), 32'h0);
    check("rst_emulti", 32'(err_multi), 32'h0);

    // basic frame 0,1,2,3 with blanks between
    fv_mark = fv_cnt;
    for (int k = 0; k < 4; k++) begin
      show_digit(k, k, 20);
      drive(4'hF, 7'h00, 3);
    end
    check("f1_pulses", fv_cnt - fv_mark, 1);
    check("f1_digits", 32'(digits), 32'h3210);
    check("f1_fc",     32'(frame_count), 32'd1);

    // glitch on digit 0 is too short to accept
    fv_mark = fv_cnt;
    show_digit(0, 0, 7);
    drive(4'hF, 7'h00, 3);
    show_digit(1, 5, 20);
    show_digit(2, 6, 20);
    show_digit(3, 7, 20);
    check("glitch_nofr", fv_cnt - fv_mark, 0);
    check("glitch_fc",   32'(frame_count), 32'd1);
    show_digit(0, 4, 20);
    check("glitch_digits", 32'(digits), 32'h7654);
    check("glitch_fc2",    32'(frame_count), 32'd2);
    drive(4'hF, 7'h00, 3);

    // illegal segment pattern
    fv_mark = fv_cnt;
    drive(4'b1110, 7'h01, 20);
    check("ill_eseg", 32'(err_seg), 32'h1);
    check("ill_nofr", fv_cnt - fv_mark, 0);
    drive(4'hF, 7'h00, 2);
    pulse_clr();
    check("ill_clr", 32'(err_seg), 32'h0);

    // two anodes low
    drive(4'b1100, 7'h7F, 20);
    check("multi_set",  32'(err_multi), 32'h1);
    check("multi_eseg", 32'(err_seg), 32'h0);
    check("multi_nofr", fv_cnt - fv_mark, 0);
    drive(4'hF, 7'h00, 2);
    pulse_clr();
    check("multi_clr", 32'(err_multi), 32'h0);
    // accept lands on the 11th posedge after the input change
    drive(4'b1100, 7'h7F, 10);
    check("multi_pre", 32'(err_multi), 32'h0);
    pulse_clr();
    check("multi_clr_same", 32'(err_multi), 32'h1);
    repeat (3) @(negedge clk);
    check("multi_hold", 32'(err_multi), 32'h1);
    drive(4'hF, 7'h00, 2);
    pulse_clr();
    check("multi_clr2", 32'(err_multi), 32'h0);

    // async reset mid-frame, then a fresh frame F,E,d,C
    show_digit(0, 0, 20);
    show_digit(1, 1, 20);
    drive(4'hF, 7'h00, 2);
    #2 reset_sync = 1'b1;
    #1;
    check("arst_fc",     32'(frame_count), 32'd0);
    check("arst_digits", 32'(digits), 32'h0);
    #4 reset_sync = 1'b0;
    @(negedge clk);
    fv_mark = fv_cnt;
    show_digit(0, 15, 20);
    show_digit(1, 14, 20);
    show_digit(2, 13, 20);
    drive(4'b0111, seg_tab[12], 10);
    check("lat_before", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("lat_pulse", 32'(frame_valid), 32'h1);
    @(negedge clk);
    check("lat_one", 32'(frame_valid), 32'h0);
    repeat (8) @(negedge clk);
    check("arst_digits2", 32'(digits), 32'hCDEF);
    check("arst_fc2",     32'(frame_count), 32'd1);
    check("arst_pulses",  fv_cnt - fv_mark, 1);
    check("arst_emulti",  32'(err_multi), 32'h0);

    // 255 more frames: frame_count wraps to 0
    fv_mark = fv_cnt;
    for (int n = 1; n < 256; n++) begin
      for (int k = 0; k < 4; k++)
        show_digit(k, (n + off_tab[k]) % 16, 13);
      if (n == 254) check("wrap_255", 32'(frame_count), 32'd255);
    end
    check("wrap_fc",     32'(frame_count), 32'd0);
    check("wrap_pulses", fv_cnt - fv_mark, 255);
    check("wrap_digits", 32'(digits), 32'h840F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
